// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: data width, MDU op encodings and MDU FSM states.
package mips_pkg;

   localparam int DATA_W = 32;

   localparam logic [2:0] MDU_MULT  = 3'b000;
   localparam logic [2:0] MDU_MULTU = 3'b001;
   localparam logic [2:0] MDU_DIV   = 3'b010;
   localparam logic [2:0] MDU_DIVU  = 3'b011;
   localparam logic [2:0] MDU_MTHI  = 3'b100;
   localparam logic [2:0] MDU_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } mdu_state_t;

endpackage

// File: rtl/mips_mdu_iter_core.sv
// One radix-2 step of the MDU datapath over a shared 2*DATA_W accumulator.
// Multiply: {product_hi, multiplier}; divide: {remainder, quotient}.
module mdu_iter_core #(
   parameter int DATA_W = 32
) (
   input  logic                  is_div,
   input  logic [2*DATA_W-1:0]   acc,
   input  logic [DATA_W-1:0]     b,
   output logic [2*DATA_W-1:0]   acc_next
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] shifted;
   logic [DATA_W:0] diff;

   always_comb begin
      sum      = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, (acc[0] ? b : '0)};
      shifted  = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
      diff     = shifted - {1'b0, b};
      acc_next = '0;
      if (is_div) begin
         // restoring: keep the shifted remainder when the trial subtract borrows
         if (diff[DATA_W])
            acc_next = {shifted[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
         else
            acc_next = {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
      end else begin
         acc_next = {sum, acc[DATA_W-1:1]};
      end
   end

endmodule

// File: rtl/mips_mdu.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// MULT/DIV take DATA_W+1 cycles; MTHI/MTLO write in a single edge.
module mips_mdu #(
   parameter int DATA_W = mips_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] rs_val,
   input  logic [DATA_W-1:0] rt_val,
   input  logic              cancel,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   import mips_pkg::*;

   localparam int CNT_W = $clog2(DATA_W);

   mdu_state_t            state;
   logic [CNT_W-1:0]      cnt;
   logic [2*DATA_W-1:0]   acc;
   logic [2*DATA_W-1:0]   acc_next;
   logic [DATA_W-1:0]     b_mag;
   logic [DATA_W-1:0]     orig_a;
   logic                  is_div;
   logic                  neg_res;
   logic                  neg_rem;
   logic                  div0;

   logic                  signed_op;
   logic                  a_neg;
   logic                  b_neg;
   logic [DATA_W-1:0]     a_in_mag;
   logic [DATA_W-1:0]     b_in_mag;
   logic [2*DATA_W-1:0]   prod;
   logic [DATA_W-1:0]     fix_hi;
   logic [DATA_W-1:0]     fix_lo;

   mdu_iter_core #(.DATA_W(DATA_W)) u_core (
      .is_div   (is_div),
      .acc      (acc),
      .b        (b_mag),
      .acc_next (acc_next)
   );

   // unsigned magnitudes: negating the most-negative value yields 2^(W-1) correctly
   always_comb begin
      signed_op = (op == MDU_MULT) || (op == MDU_DIV);
      a_neg     = signed_op & rs_val[DATA_W-1];
      b_neg     = signed_op & rt_val[DATA_W-1];
      a_in_mag  = a_neg ? -rs_val : rs_val;
      b_in_mag  = b_neg ? -rt_val : rt_val;
   end

   always_comb begin
      prod   = neg_res ? -acc : acc;
      fix_hi = prod[2*DATA_W-1:DATA_W];
      fix_lo = prod[DATA_W-1:0];
      if (is_div) begin
         if (div0) begin
            fix_lo = '1;
            fix_hi = orig_a;
         end else begin
            fix_lo = neg_res ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
            fix_hi = neg_rem ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         acc     <= '0;
         b_mag   <= '0;
         orig_a  <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         div0    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !cancel) begin
                  case (op)
                     MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                        acc     <= {{DATA_W{1'b0}}, a_in_mag};
                        b_mag   <= b_in_mag;
                        orig_a  <= rs_val;
                        is_div  <= op[1];
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        div0    <= (rt_val == '0);
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= CALC;
                     end
                     MDU_MTHI: hi <= rs_val;
                     MDU_MTLO: lo <= rs_val;
                     default: ;
                  endcase
               end
            end
            CALC: begin
               if (cancel) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  acc <= acc_next;
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_W'(DATA_W - 1))
                     state <= FIX;
               end
            end
            FIX: begin
               busy  <= 1'b0;
               state <= IDLE;
               if (!cancel) begin
                  hi   <= fix_hi;
                  lo   <= fix_lo;
                  done <= 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
